// File: rtl/mips_multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_ctrl_if
// Description : Decode inputs, memory handshake and datapath controls between
//               the multicycle MIPS controller and its datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       trap;
    logic [1:0] trap_cause;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, trap, trap_cause, state_dbg
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, trap, trap_cause, state_dbg
    );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Moore sequencer for a multicycle MIPS datapath with memory
//               wait handshake and trap. Define MIPS_MC_JR_EN to add a JR state.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    mips_multicycle_ctrl_if.master bus
);
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam int         c_WCW      = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int         c_WAIT_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11,
`ifdef MIPS_MC_JR_EN
        S_JR        = 4'd13,
`endif
        S_TRAP      = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write_u;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       fetch;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       done;
        logic       done_on_ready;
        logic       trap;
    } outs_t;

    // Output decode of a state; registered alongside the state so outputs stay Moore.
    function automatic outs_t f_decode(input state_t s);
        outs_t o;
        o = '0;
        case (s)
            S_FETCH:     begin o.mem_read = 1'b1; o.fetch = 1'b1; o.alu_src_b = 2'b01; end
            S_DECODE:    o.alu_src_b = 2'b11;
            S_MEM_ADDR:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            S_MEM_READ:  begin o.mem_read = 1'b1; o.i_or_d = 1'b1; end
            S_MEM_WB:    begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.done = 1'b1; end
            S_MEM_WRITE: begin o.mem_write = 1'b1; o.i_or_d = 1'b1; o.done_on_ready = 1'b1; end
            S_EXECUTE:   begin o.alu_src_a = 1'b1; o.alu_op = 2'b10; end
            S_R_WB:      begin o.reg_write = 1'b1; o.reg_dst = 1'b1; o.done = 1'b1; end
            S_BRANCH:    begin
                o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_write_cond = 1'b1;
                o.pc_source = 2'b01; o.done = 1'b1;
            end
            S_JUMP:      begin o.pc_write_u = 1'b1; o.pc_source = 2'b10; o.done = 1'b1; end
            S_ADDI_EX:   begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
            S_ADDI_WB:   begin o.reg_write = 1'b1; o.done = 1'b1; end
`ifdef MIPS_MC_JR_EN
            S_JR:        begin o.pc_write_u = 1'b1; o.pc_source = 2'b11; o.done = 1'b1; end
`endif
            S_TRAP:      o.trap = 1'b1;
            default:     o = '0;
        endcase
        return o;
    endfunction

    state_t           r_state;
    logic [c_WCW-1:0] r_wait_cnt;
    logic [1:0]       r_cause;
    outs_t            r_outs;

    state_t           w_state_nxt;
    logic [c_WCW-1:0] w_wait_nxt;
    logic [1:0]       w_cause_nxt;
    logic             w_mem_state;
    logic             w_timeout;

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE);
        w_timeout   = (MEM_TIMEOUT != 0) && w_mem_state && !bus.mem_ready &&
                      (r_wait_cnt == c_WCW'(c_WAIT_LAST));
        case (r_state)
            S_FETCH:     if (bus.mem_ready) w_state_nxt = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    c_OP_LW, c_OP_SW: w_state_nxt = S_MEM_ADDR;
`ifdef MIPS_MC_JR_EN
                    c_OP_RTYPE: w_state_nxt = (bus.funct == 6'b001000) ? S_JR : S_EXECUTE;
`else
                    c_OP_RTYPE: w_state_nxt = S_EXECUTE;
`endif
                    c_OP_BEQ:   w_state_nxt = S_BRANCH;
                    c_OP_J:     w_state_nxt = S_JUMP;
                    c_OP_ADDI:  w_state_nxt = S_ADDI_EX;
                    default: begin
                        w_state_nxt = S_TRAP;
                        w_cause_nxt = 2'b01;
                    end
                endcase
            end
            S_MEM_ADDR:  w_state_nxt = (bus.opcode == c_OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (bus.mem_ready) w_state_nxt = S_MEM_WB;
            S_MEM_WRITE: if (bus.mem_ready) w_state_nxt = S_FETCH;
            S_EXECUTE:   w_state_nxt = S_R_WB;
            S_ADDI_EX:   w_state_nxt = S_ADDI_WB;
            S_TRAP:      w_state_nxt = S_TRAP;
            default:     w_state_nxt = S_FETCH;
        endcase
        if (w_timeout) begin
            w_state_nxt = S_TRAP;
            w_cause_nxt = 2'b10;
        end
        // The wait counter only survives an unready cycle spent in the same memory state.
        if ((w_state_nxt != r_state) || bus.mem_ready || !w_mem_state) begin
            w_wait_nxt = '0;
        end else begin
            w_wait_nxt = r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
            r_cause    <= 2'b00;
            r_outs     <= f_decode(S_FETCH);
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_cause    <= w_cause_nxt;
            r_outs     <= f_decode(w_state_nxt);
        end
    end

    logic w_run;
    assign w_run = ~reset;

    assign bus.pc_write      = w_run & (r_outs.pc_write_u | (r_outs.fetch & bus.mem_ready));
    assign bus.pc_write_cond = w_run & r_outs.pc_write_cond;
    assign bus.i_or_d        = r_outs.i_or_d;
    assign bus.mem_read      = w_run & r_outs.mem_read;
    assign bus.mem_write     = w_run & r_outs.mem_write;
    assign bus.ir_write      = w_run & r_outs.fetch & bus.mem_ready;
    assign bus.mem_to_reg    = r_outs.mem_to_reg;
    assign bus.reg_dst       = r_outs.reg_dst;
    assign bus.reg_write     = w_run & r_outs.reg_write;
    assign bus.alu_src_a     = r_outs.alu_src_a;
    assign bus.alu_src_b     = r_outs.alu_src_b;
    assign bus.alu_op        = r_outs.alu_op;
    assign bus.pc_source     = r_outs.pc_source;
    assign bus.instr_done    = w_run & (r_outs.done | (r_outs.done_on_ready & bus.mem_ready));
    assign bus.trap          = r_outs.trap;
    assign bus.trap_cause    = r_cause;
    assign bus.state_dbg     = r_state;

`ifndef MIPS_MC_JR_EN
    logic w_unused_funct;
    assign w_unused_funct = &{1'b0, bus.funct};
`endif
endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multicycle_ctrl
// Description : Directed self-checking bench for mips_multicycle_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    int   n_mw;
    int   n_rw;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl #(.MEM_TIMEOUT(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] strobes();
        return {bus.pc_write, bus.pc_write_cond, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.reg_write, bus.instr_done};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        check("reset_strobes", 32'(strobes()), 32'h0);
        reset = 1'b0;
        #1;
        check("reset_state", 32'(bus.state_dbg), 32'd0);
        check("reset_trap", {30'd0, bus.trap, 1'b0} | 32'(bus.trap_cause), 32'd0);
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        reset = 1'b1;
        bus.opcode = 6'b100011; bus.funct = 6'd0; bus.mem_ready = 1'b1;
        tick(); tick();
        check("rst_strobes", 32'(strobes()), 32'h0);
        check("rst_state", 32'(bus.state_dbg), 32'd0);
        check("rst_cause", 32'(bus.trap_cause), 32'd0);
        reset = 1'b0;
        #1;
        // lw: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB
        check("lw_fetch_strobes", 32'(strobes()), 32'b1010100);
        check("lw_fetch_sel", {bus.i_or_d, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source}, 32'b00010000);
        tick(); check("lw_dec_state", 32'(bus.state_dbg), 32'd1);
        check("lw_dec_srcb", 32'(bus.alu_src_b), 32'd3);
        check("lw_dec_strobes", 32'(strobes()), 32'h0);
        tick(); check("lw_addr_state", 32'(bus.state_dbg), 32'd2);
        check("lw_addr_sel", {bus.alu_src_a, bus.alu_src_b, bus.alu_op}, 32'b11000);
        tick(); check("lw_rd_state", 32'(bus.state_dbg), 32'd3);
        check("lw_rd_strobes", {bus.i_or_d, strobes()}, 32'b10010000);
        tick(); check("lw_wb_state", 32'(bus.state_dbg), 32'd4);
        check("lw_wb_strobes", {bus.mem_to_reg, bus.reg_dst, strobes()}, 32'b100000011);
        tick(); check("lw_next_fetch", 32'(bus.state_dbg), 32'd0);

        // sw with three wait states in MEM_WRITE
        bus.opcode = 6'b101011;
        tick(); tick();
        bus.mem_ready = 1'b0;
        tick();
        n_mw = 0; n_rw = 0;
        for (int i = 0; i < 3; i++) begin
            check("sw_wait_state", 32'(bus.state_dbg), 32'd5);
            check("sw_wait_done", 32'(bus.instr_done), 32'd0);
            if (bus.mem_write) n_mw++;
            if (bus.reg_write) n_rw++;
            tick();
        end
        bus.mem_ready = 1'b1;
        #1;
        check("sw_done", 32'(bus.instr_done), 32'd1);
        if (bus.mem_write) n_mw++;
        if (bus.reg_write) n_rw++;
        check("sw_mw_cycles", 32'(n_mw), 32'd4);
        check("sw_no_regwr", 32'(n_rw), 32'd0);
        tick(); check("sw_next_fetch", 32'(bus.state_dbg), 32'd0);

        // beq then j, three cycles each
        bus.opcode = 6'b000100;
        tick(); tick();
        check("beq_state", 32'(bus.state_dbg), 32'd8);
        check("beq_out", {bus.pc_write_cond, bus.pc_write, bus.pc_source, bus.alu_op, bus.instr_done}, 32'b1001011);
        tick(); check("beq_next_fetch", 32'(bus.state_dbg), 32'd0);
        bus.opcode = 6'b000010;
        tick(); tick();
        check("j_state", 32'(bus.state_dbg), 32'd9);
        check("j_out", {bus.pc_write_cond, bus.pc_write, bus.pc_source, bus.instr_done}, 32'b01101);
        tick(); check("j_next_fetch", 32'(bus.state_dbg), 32'd0);

        // addi
        bus.opcode = 6'b001000;
        tick(); tick();
        check("addi_ex", {28'(bus.state_dbg), bus.alu_src_b, bus.alu_op}, {28'd10, 4'b1000});
        tick();
        check("addi_wb", {28'(bus.state_dbg), bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.instr_done}, {28'd11, 4'b1001});
        tick(); check("addi_next_fetch", 32'(bus.state_dbg), 32'd0);

        // R-type with funct=001000 (jr)
        bus.opcode = 6'b000000; bus.funct = 6'b001000;
        tick(); tick();
`ifdef MIPS_MC_JR_EN
        check("jr_state", 32'(bus.state_dbg), 32'd13);
        check("jr_out", {bus.pc_write, bus.pc_source, bus.reg_write, bus.instr_done}, 32'b11101);
`else
        check("rjr_ex", {28'(bus.state_dbg), bus.alu_src_a, bus.alu_src_b, bus.alu_op[1]}, {28'd6, 4'b1001});
        tick();
        check("rjr_wb", {28'(bus.state_dbg), bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.instr_done}, {28'd7, 4'b1101});
`endif
        tick(); check("r_next_fetch", 32'(bus.state_dbg), 32'd0);

        // illegal opcode
        bus.opcode = 6'b111111;
        tick(); check("ill_dec", 32'(bus.state_dbg), 32'd1);
        tick();
        check("ill_trap", {29'(bus.state_dbg), bus.trap, bus.trap_cause}, {29'd12, 3'b101});
        for (int i = 0; i < 20; i++) begin
            check("ill_hold", {25'(bus.state_dbg), strobes()}, {25'd12, 7'd0});
            tick();
        end
        do_reset();

        // timeout: stuck not-ready in FETCH traps after 16 cycles
        bus.opcode = 6'b100011;
        bus.mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 15; i++) tick();
        check("to_cycle16", {31'(bus.state_dbg), bus.ir_write}, 32'd0);
        tick();
        check("to_trap", {29'(bus.state_dbg), bus.trap, bus.trap_cause}, {29'd12, 3'b110});
        do_reset();

        // ready arriving on cycle 16 wins over the timeout
        bus.mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 15; i++) tick();
        bus.mem_ready = 1'b1;
        #1;
        check("to_ready_irw", 32'(bus.ir_write), 32'd1);
        tick();
        check("to_ready_dec", {30'(bus.state_dbg), bus.trap, 1'b0}, {30'd1, 2'b00});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
